fetch_stage: RTL and testbench

- Instruction-fetch stage for the MIPS core, directly upstream of the main control decoder.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Captures returned words into an IF/ID register with a valid/ready handshake; id_inst[31:26] drives the decoder's op input.
- Applies PC redirects for taken branches and jumps, and discards wrong-path fetches.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 35 +++
 rtl/if_skid_buf.sv | 42 ++++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
// Imported by the fetch stage, its skid buffer and the decode side.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the
// IF/ID valid/ready handshake and the decode-side redirect.
interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output inst_req, inst_addr,
        input  inst_rvalid, inst_rdata,
        output id_valid, id_inst, id_pc, id_pc_plus4,
        input  id_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_rvalid, inst_rdata,
        input  id_valid, id_inst, id_pc, id_pc_plus4,
        output id_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {inst, pc} buffer that parks a returned word while
// decode stalls; flush wins over load, load wins over pop.
module if_skid_buf
    import core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            inst_q  <= NOP;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding memory requests, IF/ID register
// with a one-entry skid, and redirect handling with wrong-path kill.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic           clk,
    input  logic           resetn,
    fetch_stage_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic         idv_q, idv_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  idpc_q, idpc_d;
    logic [31:0]  idpc4_q, idpc4_d;

    logic         skid_load, skid_pop, skid_flush;
    logic         skid_v;
    logic [31:0]  skid_inst, skid_pc;

    logic         id_free;
    logic [31:0]  pc_inc;
    logic [31:0]  tgt;

    assign id_free = !idv_q || bus.id_ready;
    assign pc_inc  = pc_next(pc_q);
    assign tgt     = {bus.redirect_pc[31:2], 2'b00};

    if_skid_buf u_skid (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .flush_i (skid_flush),
        .inst_i  (bus.inst_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_v),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            idv_q   <= 1'b0;
            inst_q  <= NOP;
            idpc_q  <= '0;
            idpc4_q <= 32'd4;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            idv_q   <= idv_d;
            inst_q  <= inst_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        req_d      = 1'b0;
        addr_d     = addr_q;
        idv_d      = idv_q;
        inst_d     = inst_q;
        idpc_d     = idpc_q;
        idpc4_d    = idpc4_q;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_flush = 1'b0;

        if (idv_q && bus.id_ready) idv_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.inst_rvalid) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end else if (id_free) begin
                        idv_d   = 1'b1;
                        inst_d  = bus.inst_rdata;
                        idpc_d  = pc_q;
                        idpc4_d = pc_inc;
                        pc_d    = pc_inc;
                        req_d   = 1'b1;
                        addr_d  = pc_inc;
                    end else begin
                        skid_load = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.id_ready && skid_v) begin
                    skid_pop = 1'b1;
                    idv_d    = 1'b1;
                    inst_d   = skid_inst;
                    idpc_d   = skid_pc;
                    idpc4_d  = pc_next(skid_pc);
                    req_d    = 1'b1;
                    addr_d   = pc_q;
                    state_d  = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; an in-flight word is killed.
        if (bus.redirect_valid) begin
            pc_d       = tgt;
            idv_d      = 1'b0;
            skid_flush = 1'b1;
            skid_load  = 1'b0;
            skid_pop   = 1'b0;
            unique case (state_q)
                S_WAIT: begin
                    state_d = S_WAIT;
                    if (bus.inst_rvalid) begin
                        kill_d = 1'b0;
                        req_d  = 1'b1;
                        addr_d = tgt;
                    end else begin
                        kill_d = 1'b1;
                        req_d  = 1'b0;
                    end
                end
                S_HOLD: begin
                    req_d   = 1'b1;
                    addr_d  = tgt;
                    state_d = S_WAIT;
                end
                default: addr_d = tgt;
            endcase
        end
    end

    assign bus.inst_req    = req_q;
    assign bus.inst_addr   = addr_q;
    assign bus.id_valid    = idv_q;
    assign bus.id_inst     = inst_q;
    assign bus.id_pc       = idpc_q;
    assign bus.id_pc_plus4 = idpc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage with a memory model
// and an in-order fetch-stream reference.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errs = 0;
    int          hs = 0;
    int          hs0;
    logic [31:0] exp_req;
    logic [31:0] exp_id;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    int          lat = 1;
    bit          rnd_lat = 1'b0;
    bit          ok;
    bit          found;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h8C01_0004;
        if (a == 32'h0000_0004) return 32'hAC01_0008;
        return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(bus.inst_req), 32'h0);
        chk({tag, "_addr"}, bus.inst_addr, 32'h0);
        chk({tag, "_idv"}, 32'(bus.id_valid), 32'h0);
        chk({tag, "_inst"}, bus.id_inst, 32'h0);
        chk({tag, "_pc"}, bus.id_pc, 32'h0);
        chk({tag, "_pc4"}, bus.id_pc_plus4, 32'h4);
    endtask

    // Memory side: respond once per request after the chosen latency.
    task automatic tick();
        bit busy;
        @(negedge clk);
        busy = pend;
        bus.inst_rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                bus.inst_rvalid = 1'b1;
                bus.inst_rdata  = word(paddr);
                pend = 1'b0;
            end
        end
        if (bus.inst_req) begin
            chk("one_outstanding", 32'(busy), 32'h0);
            chk("req_addr", bus.inst_addr, exp_req);
            exp_req = bus.inst_addr + 32'd4;
            pend  = 1'b1;
            paddr = bus.inst_addr;
            cnt   = rnd_lat ? int'($urandom_range(4, 1)) : lat;
        end
    endtask

    // Decode side: consume, check against the expected stream, redirect.
    task automatic drive(input bit rdy, input bit rd = 1'b0,
                         input logic [31:0] tgt = 32'h0);
        if (bus.id_valid && rdy) begin
            chk("id_pc", bus.id_pc, exp_id);
            chk("id_inst", bus.id_inst, word(exp_id));
            chk("id_pc_plus4", bus.id_pc_plus4, exp_id + 32'd4);
            exp_id = exp_id + 32'd4;
            hs++;
        end
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        if (rd && bus.id_valid && rdy) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = tgt;
            exp_id  = tgt & ~32'h3;
            exp_req = exp_id;
        end
        bus.id_ready = rdy;
    endtask

    task automatic step(input bit rdy, input bit rd = 1'b0,
                        input logic [31:0] tgt = 32'h0);
        tick();
        drive(rdy, rd, tgt);
    endtask

    task automatic wait_id(input string tag, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (bus.id_valid) begin
                seen = 1'b1;
                break;
            end
            drive(1'b1);
        end
        chk(tag, 32'(seen), 32'h1);
    endtask

    task automatic align(output bit got);
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.id_valid && bus.inst_req) begin
                got = 1'b1;
                break;
            end
            drive(1'b1);
        end
    endtask

    initial begin
        logic [31:0] held;
        bus.inst_rvalid    = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        exp_req = 32'h0;
        exp_id  = 32'h0;

        repeat (3) @(negedge clk);
        chk_reset("rst");

        // First fetches after reset release
        resetn = 1'b1;
        bus.id_ready = 1'b1;
        tick();
        chk("t1_first_req", 32'(bus.inst_req), 32'h1);
        drive(1'b1);
        wait_id("t1_id_valid", 10);
        chk("t1_pc", bus.id_pc, 32'h0);
        chk("t1_inst", bus.id_inst, 32'h8C01_0004);
        chk("t1_next_addr", bus.inst_addr, 32'h4);
        drive(1'b1);

        hs0 = hs;
        repeat (20) step(1'b1);
        chk("t1_throughput", 32'(hs - hs0), 32'd10);

        // Decode stall while a response lands in the skid
        align(ok);
        chk("t2_align", 32'(ok), 32'h1);
        held = bus.id_pc;
        drive(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_noreq", 32'(bus.inst_req), 32'h0);
            chk("t2_hold_pc", bus.id_pc, held);
            drive(1'b0);
        end
        tick();
        drive(1'b1);
        tick();
        chk("t2_pop_req", 32'(bus.inst_req), 32'h1);
        chk("t2_pop_valid", 32'(bus.id_valid), 32'h1);
        chk("t2_pop_pc", bus.id_pc, held + 32'd4);
        drive(1'b1);

        // Redirect with a 3-cycle response outstanding
        lat = 3;
        align(ok);
        chk("t3_align", 32'(ok), 32'h1);
        drive(1'b1, 1'b1, 32'h0000_0100);
        wait_id("t3_id_valid", 20);
        chk("t3_pc", bus.id_pc, 32'h0000_0100);
        drive(1'b1);

        // Redirect in the same cycle as the response
        lat = 1;
        align(ok);
        chk("t4_align", 32'(ok), 32'h1);
        drive(1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0203);
        tick();
        chk("t4_req", 32'(bus.inst_req), 32'h1);
        chk("t4_addr", bus.inst_addr, 32'h0000_0200);
        drive(1'b1);
        wait_id("t4_id_valid", 10);
        chk("t4_pc", bus.id_pc, 32'h0000_0200);
        drive(1'b1);

        // PC wrap at the top of the address space
        align(ok);
        chk("t6_align", 32'(ok), 32'h1);
        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.id_valid && bus.id_pc == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
            drive(1'b1);
        end
        chk("t6_found", 32'(found), 32'h1);
        chk("t6_pc4", bus.id_pc_plus4, 32'h0);
        chk("t6_req", 32'(bus.inst_req), 32'h1);
        chk("t6_addr", bus.inst_addr, 32'h0);
        drive(1'b1);
        wait_id("t6_id_valid", 10);
        chk("t6_wrap_pc", bus.id_pc, 32'h0);
        drive(1'b1);

        // Asynchronous reset while holding a skid word
        align(ok);
        chk("t5_align", 32'(ok), 32'h1);
        drive(1'b0);
        repeat (3) step(1'b0);
        resetn = 1'b0;
        pend = 1'b0;
        bus.inst_rvalid = 1'b0;
        exp_req = 32'h0;
        exp_id  = 32'h0;
        #1;
        chk_reset("t5_async");
        @(negedge clk);
        chk_reset("t5_held");
        resetn = 1'b1;
        bus.id_ready = 1'b1;
        tick();
        chk("t5_first_req", 32'(bus.inst_req), 32'h1);
        chk("t5_first_addr", bus.inst_addr, 32'h0);
        drive(1'b1);
        wait_id("t5_id_valid", 10);
        chk("t5_pc", bus.id_pc, 32'h0);
        drive(1'b1);

        // Random latency, stalls and redirects against the stream model
        rnd_lat = 1'b1;
        hs0 = hs;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
                 $urandom);
        end
        chk("rand_progress", 32'(hs > hs0 + 20), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
